// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit with HI/LO result registers. It produces one
//   result bit per clock: shift-add for MULT/MULTU and a restoring divider for
//   DIV/DIVU. Signed operations are run on magnitudes, and the sign is fixed up
//   in a final cycle. Direct writes to HI/LO (mthi/mtlo) are accepted only
//   while the unit is idle.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low (asserted when 0)
//   start        launch an operation; sampled only when idle
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         rs / rt operands (multiplicand, multiplier / dividend, divisor)
//   hi_we, lo_we direct write of wdata into HI / LO while idle
//   wdata        direct-write data
//   busy         operation in progress
//   done         one-cycle pulse after HI/LO are updated by an operation
//   div_by_zero  sticky flag for a divide with b == 0; cleared by the next start
//   hi, lo       result registers
module mult_div_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;        // {upper, lower}: product, or {remainder, dividend/quotient}
  logic [WIDTH-1:0]     operand_q;  // multiplicand for multiply, divisor for divide
  logic                 is_div_q;
  logic                 sign_q;
  logic                 sign_r;
  logic                 zero_div;

  // Operand magnitudes. op[0]==0 selects the signed variants.
  logic                 signed_op;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  assign signed_op = ~op[0];
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  // One iteration of each algorithm.
  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift right. The carry is kept.
  // Divide: shift {remainder, dividend} left. The bit that leaves acc is kept
  // as the top bit of the trial value. When that bit is 1 the partial
  // remainder is already larger than any divisor, so the subtraction succeeds.
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_top;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_top  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_top - {1'b0, operand_q};
    div_next = '0;
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign-corrected results, used in the FIX cycle.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign prod_fix = sign_q ? -acc : acc;
  assign quot_fix = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // Control FSM and result registers.
  // Divide by zero skips RUN entirely. The raw dividend is parked in acc so
  // that FIX can return it unchanged in HI.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      operand_q   <= '0;
      is_div_q    <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div_q    <= op[1];
            sign_q      <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r      <= signed_op & a[WIDTH-1];
            div_by_zero <= 1'b0;
            cnt         <= CNT_W'(WIDTH);
            busy        <= 1'b1;
            if (op[1] && (b == '0)) begin
              zero_div  <= 1'b1;
              acc       <= {{WIDTH{1'b0}}, a};
              operand_q <= '0;
              state     <= FIX;
            end else begin
              zero_div <= 1'b0;
              state    <= RUN;
              if (op[1]) begin
                operand_q <= b_mag;
                acc       <= {{WIDTH{1'b0}}, a_mag};
              end else begin
                operand_q <= a_mag;
                acc       <= {{WIDTH{1'b0}}, b_mag};
              end
            end
          end
        end
        RUN: begin
          acc <= is_div_q ? div_next : mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (zero_div) begin
            hi          <= acc[WIDTH-1:0];
            lo          <= {WIDTH{1'b1}};
            div_by_zero <= 1'b1;
          end else if (is_div_q) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed bench for mult_div_unit with WIDTH=32. Each operation pushes its
//   hand-computed {div_by_zero, hi, lo} into a scoreboard queue. A monitor
//   pops the queue and compares whenever done is seen. The stimulus side
//   checks latency, busy duration, done pulse width, and reset behaviour.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [64:0] sb[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare the result registers whenever the DUT signals completion.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [64:0] e;
        e = sb.pop_front();
        checkOutput("hi", {32'd0, hi}, {32'd0, e[63:32]});
        checkOutput("lo", {32'd0, lo}, {32'd0, e[31:0]});
        checkOutput("div_by_zero", {63'd0, div_by_zero}, {63'd0, e[64]});
      end
    end
  end

  // Launch one operation and follow it to done. If inj_cycle > 0, a second
  // start and HI/LO writes of 0xAA are driven mid-operation. The unit must
  // ignore them.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input logic exp_dbz, input int exp_lat, input int inj_cycle);
    int n;
    int busy_cnt;
    bit got;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    sb.push_back({exp_dbz, exp_hi, exp_lo});
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'b10;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0;
    checkOutput("dbz_cleared_on_start", {63'd0, div_by_zero}, 64'd0);
    checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
    n = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
      if (!got && n == inj_cycle) begin
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd5;
        b     = 32'd3;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hAA;
      end
    end
    checkOutput("latency", 64'(n), 64'(exp_lat));
    checkOutput("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
    checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("done_pulse_width", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int dcount;
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33, 0);
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, 0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0);
    applyStimulus(2'b11, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1,  0);
    applyStimulus(2'b01, 32'd6,         32'd7,          32'h0,         32'd42,        1'b0, 33, 0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 33, 0);
    applyStimulus(2'b11, 32'd100,       32'd7,          32'd2,         32'd14,        1'b0, 33, 0);
    applyStimulus(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33, 0);
    applyStimulus(2'b01, 32'h1234_5678, 32'h100,        32'h12,        32'h3456_7800, 1'b0, 33, 10);

    // Direct HI/LO writes while idle take effect at the next edge.
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hAA;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    checkOutput("idle_hi_write", {32'd0, hi}, 64'hAA);
    checkOutput("idle_hi_write_lo_kept", {32'd0, lo}, 64'h3456_7800);
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h55;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    checkOutput("idle_lo_write", {32'd0, lo}, 64'h55);

    // Reset in the middle of a DIV. No done pulse may follow.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    a     = 32'hFFFF_FFF9;
    b     = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midop_reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("midop_reset_done", {63'd0, done}, 64'd0);
    checkOutput("midop_reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("midop_reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    checkOutput("no_done_after_reset", 64'(dcount), 64'd0);
    checkOutput("idle_after_reset", {63'd0, busy}, 64'd0);

    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
